uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares one uart_tx instance between NUM_REQ byte sources (e.g. loopback echo, status reporter, debug dump).
//  Round-robin arbitration; sequences the uart_tx start/ready handshake one byte at a time.
//  Sits between the requesters and uart_tx in the test harness top level.
// PARAMETERS
//  DATA_BITS     8   width of one UART character; matches uart_tx DATA_BITS
//  NUM_REQ       4   number of requesters, 2..8
//  MAX_BURST     16  max consecutive bytes per grant (burst mode only), >=1
//  BUSY_TIMEOUT  8   cycles to wait for tx_ready to fall after tx_start, >=2
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  asynchronous, active-high reset
//  req_valid    in   NUM_REQ            requester i has a byte on req_data
//  req_data     in   NUM_REQ*DATA_BITS  byte i at [i*DATA_BITS +: DATA_BITS]
//  req_ack      out  NUM_REQ            one-cycle pulse: byte i accepted
//  tx_ready     in   1                  from uart_tx ready (high = idle)
//  tx_start     out  1                  to uart_tx start, one-cycle pulse
//  tx_data      out  DATA_BITS          to uart_tx data_in, stable while busy
//  grant_id     out  clog2(NUM_REQ)     index of last/current grantee
//  busy         out  1                  high outside IDLE
//  err_timeout  out  1                  sticky: uart_tx never went busy
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; tx_start=0, tx_data=0, req_ack=0, grant_id=0, busy=0,
//   err_timeout=0, rr pointer=NUM_REQ-1 (req 0 wins first), burst count=0. Byte in flight is dropped.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: if tx_ready && |req_valid: pick first set bit searching from ptr+1 modulo NUM_REQ;
//   register tx_data<=req_data[g], grant_id<=g, req_ack[g]<=1, ptr<=g; -> ISSUE.
//  ISSUE: tx_start=1 for exactly this cycle; req_ack=0; timer=0; -> WAIT_BUSY.
//  WAIT_BUSY: tx_ready low -> WAIT_DONE. Else timer++; at timer==BUSY_TIMEOUT-1 set err_timeout,
//   -> IDLE (byte lost; no re-ack).
//  WAIT_DONE: tx_ready high -> IDLE. No timeout (uart_tx frame length bounded).
//  Latency: req_valid high at cycle N with tx idle -> req_ack at N+1, tx_start at N+2.
//  Requester rule: hold req_valid/req_data until req_ack; may drop valid same cycle as ack.
//   Data sampled only in IDLE grant cycle; later changes ignored.
//  Simultaneous requests: exactly one ack per grant; losers keep waiting, no starvation
//   (every waiting requester served within NUM_REQ grants).
//  req_valid rising while tx_ready low in IDLE: wait, no ack.
//  Throughput: max one byte per uart_tx frame + 3 cycles.
//  err_timeout clears only on rst.
// CONFIGURATION
//  UART_TX_SCHED_BURST_EN defined: in IDLE, if grantee ptr still has req_valid and
//   burst count < MAX_BURST-1, it is regranted ahead of rr search (count++); otherwise normal rr
//   search, count=0. Any requester switch resets count.
//  Undefined: strict round-robin every byte; MAX_BURST ignored; no burst counter logic.
// STRUCTURE
//  Shared include uart_defs.vh: FSM state encodings (2-bit), clog2 function, default DATA_BITS.
//  One sub-module: rr_arbiter (req vector + ptr in, one-hot grant + index + any out; combinational).
//  Counters (timeout, burst) and FSM live in uart_tx_sched.
// TESTING  (bench uses real uart_tx, CLKS_PER_BIT=4, plus a stub mode for tx_ready)
//  1 Single req: req_valid=0001, data0=8'hA5 -> ack0 at +1, tx_start at +2, line shows 0xA5 frame.
//  2 Contention: all 4 valid, data=11,22,33,44 held -> serial order 11,22,33,44, one ack each.
//  3 Fairness: req0 always valid, req2 valid once -> req2 granted within 2 bytes (burst off).
//  4 Timeout: stub tx_ready stuck high -> err_timeout at tx_start+7, FSM IDLE, sticky until rst.
//  5 Reset mid-frame: assert rst in WAIT_DONE -> all outputs 0 same cycle, next grant is req 0.
//  6 Burst (macro on, MAX_BURST=3): req1 and req3 always valid -> order 1,1,1,3,3,3,1...

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx_sched block: FSM state encoding,
// a constant-function clog2 and the default UART character width.
package uart_tx_sched_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;

  // Scheduler FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr+1 (modulo NUM_REQ) and grants the first set bit.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    index of the previous grantee
//   gnt  out NUM_REQ  one-hot grant (zero when no request)
//   idx  out IDX_W    index of the granted requester
//   any  out 1        at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_c;

  // First set bit after ptr, wrapping; ptr itself is checked last.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand_c]) begin
        any         = 1'b1;
        gnt[cand_c] = 1'b1;
        idx         = cand_c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx between NUM_REQ byte sources.
// Round-robin arbitration, one byte per grant, sequencing the uart_tx
// start/ready handshake: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
// Optional feature macro: UART_TX_SCHED_BURST_EN lets the current grantee keep
// the channel for up to MAX_BURST consecutive bytes.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    requester i has a byte on req_data
//   req_data     byte i at [i*DATA_BITS +: DATA_BITS]
//   req_ack      one-cycle pulse: byte i accepted
//   tx_ready     uart_tx idle
//   tx_start     one-cycle start pulse to uart_tx
//   tx_data      byte to uart_tx, stable while busy
//   grant_id     index of last/current grantee
//   busy         high outside IDLE
//   err_timeout  sticky: uart_tx never went busy after a start
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           tx_ready,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic [clog2(NUM_REQ)-1:0]      grant_id,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned TMR_W = clog2(BUSY_TIMEOUT) + 1;

  // Elaboration-time parameter range checks.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || BUSY_TIMEOUT < 2) begin : g_bad_param
    $error("uart_tx_sched: parameter out of range");
  end

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [NUM_REQ-1:0]   sel_onehot_c;
  logic [IDX_W-1:0]     sel_idx_c;
  logic                 sel_any_c;
  logic [DATA_BITS-1:0] sel_data_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef UART_TX_SCHED_BURST_EN
  localparam int unsigned BURST_W = clog2(MAX_BURST) + 1;

  logic [BURST_W-1:0] burst_cnt;
  logic               burst_live;   // ptr refers to a real previous grant
  logic               burst_hold_c;

  assign burst_hold_c = burst_live && req_valid[ptr] &&
                        (burst_cnt < BURST_W'(MAX_BURST - 1));

  // Previous grantee is regranted ahead of the round-robin search while its burst lasts.
  always_comb begin
    sel_onehot_c = arb_gnt;
    sel_idx_c    = arb_idx;
    sel_any_c    = arb_any;
    if (burst_hold_c) begin
      sel_onehot_c = NUM_REQ'(1) << ptr;
      sel_idx_c    = ptr;
      sel_any_c    = 1'b1;
    end
  end
`else
  assign sel_onehot_c = arb_gnt;
  assign sel_idx_c    = arb_idx;
  assign sel_any_c    = arb_any;
`endif

  assign sel_data_c = req_data[32'(sel_idx_c)*DATA_BITS +: DATA_BITS];

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_TX_SCHED_BURST_EN
      burst_cnt   <= '0;
      burst_live  <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      case (state)
        ST_IDLE: begin
          if (tx_ready && sel_any_c) begin
            tx_data  <= sel_data_c;
            grant_id <= sel_idx_c;
            req_ack  <= sel_onehot_c;
            ptr      <= sel_idx_c;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
`ifdef UART_TX_SCHED_BURST_EN
            burst_live <= 1'b1;
            if (burst_hold_c) burst_cnt <= burst_cnt + BURST_W'(1);
            else              burst_cnt <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          tx_start <= 1'b1;
          timer    <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= ST_WAIT_DONE;
          end else if (timer == TMR_W'(BUSY_TIMEOUT - 2)) begin
            // Incremented timer would reach BUSY_TIMEOUT-1: give up on this byte.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx stub
// (frame = 10 bits x 4 clocks, or stuck-ready for the timeout case).
module tb_uart_tx_sched;

  localparam int unsigned DW    = 8;
  localparam int unsigned NR    = 4;
  localparam int unsigned FRAME = 40;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ack;
  logic              tx_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err_timeout;

  uart_tx_sched #(
    .DATA_BITS    (DW),
    .NUM_REQ      (NR),
    .MAX_BURST    (3),
    .BUSY_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    logic        rst_first;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  n;
    logic [7:0]  order;   // expected grant index k at [2k +: 2]
  } vec_t;

  exp_t       tx_q[$];
  logic [1:0] ack_q[$];
  int         ack_log[$];
  logic [NR-1:0] hold;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  frame_cnt = 0;
  bit  stuck = 0;
  bit  sb_en = 1;
  bit  seen_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, run the uart stub, scoreboard and requesters.
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (tx_start) begin
      seen_start = 1;
      if (sb_en) begin
        if (tx_q.size() == 0) check("tx_start_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        else begin
          e = tx_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.idx));
        end
      end
      if (!stuck) frame_cnt = FRAME;
    end
    if (frame_cnt > 0) begin
      tx_ready = 1'b0;
      frame_cnt--;
    end else begin
      tx_ready = 1'b1;
    end
    if (req_ack != '0) begin
      for (int i = 0; i < NR; i++) if (req_ack[i]) begin
        ack_log.push_back(i);
        if (!hold[i]) req_valid[i] = 1'b0;
      end
      if (sb_en) begin
        if (ack_q.size() == 0) check("req_ack_unexpected", 32'(req_ack), 32'h0);
        else check("req_ack", 32'(req_ack), 32'(4'b0001 << ack_q.pop_front()));
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (tx_q.size() == 0 && ack_q.size() == 0 && !busy && tx_ready) done = 1;
    end
    check("wait_idle_in_budget", 32'(done), 32'h1);
  endtask

  task automatic wait_acks(input int count, input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (ack_log.size() >= count) done = 1;
    end
    check("wait_acks_in_budget", 32'(done), 32'h1);
  endtask

  task automatic clear_bench();
    req_valid = '0;
    req_data  = '0;
    hold      = '0;
    tx_q.delete();
    ack_q.delete();
    ack_log.delete();
    frame_cnt = 0;
    tx_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_bench();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] d);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = d;
    tx_q.push_back(e);
    ack_q.push_back(2'(idx));
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_bench();
    #1;
    // Reset state.
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_req_ack", 32'(req_ack), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err_timeout", 32'(err_timeout), 32'h0);
    do_reset();

    // Single request latency: ack at +1, start at +2.
    req_valid = 4'b0001;
    req_data  = 32'h0000_00A5;
    push_exp(0, 8'hA5);
    tick();
    check("lat_ack", 32'(ack_log.size()), 32'h1);
    check("lat_no_start_yet", 32'(tx_start), 32'h0);
    check("lat_busy", 32'(busy), 32'h1);
    tick();
    check("lat_start", 32'(tx_start), 32'h1);
    wait_idle(200);

    // Table of simultaneous-request patterns; rr pointer carries between rows.
    vecs[0] = '{1'b1, 4'b0001, 32'h0000_00A5, 3'd1, 8'h00};
    vecs[1] = '{1'b1, 4'b1111, 32'h4433_2211, 3'd4, 8'hE4};
    vecs[2] = '{1'b0, 4'b1010, 32'hB300_B100, 3'd2, 8'h0D};
    vecs[3] = '{1'b0, 4'b0101, 32'h00C2_00C0, 3'd2, 8'h08};
    vecs[4] = '{1'b0, 4'b1001, 32'hD300_00D0, 3'd2, 8'h03};
    vecs[5] = '{1'b0, 4'b0100, 32'h00E2_0000, 3'd1, 8'h02};
    vecs[6] = '{1'b0, 4'b1111, 32'hF3F2_F1F0, 3'd4, 8'h93};
    vecs[7] = '{1'b1, 4'b0011, 32'h0000_7170, 3'd2, 8'h04};
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_first) do_reset();
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        int gi;
        gi = int'(vecs[v].order[2*k +: 2]);
        push_exp(gi, vecs[v].data[8*gi +: 8]);
      end
      req_data  = vecs[v].data;
      req_valid = vecs[v].mask;
      wait_idle(1000);
    end

`ifndef UART_TX_SCHED_BURST_EN
    // Fairness: req0 always valid, req2 valid once -> served next.
    do_reset();
    sb_en = 0;
    hold[0] = 1'b1;
    req_data = 32'h0052_0050;
    req_valid = 4'b0001;
    wait_acks(1, 200);
    req_valid[2] = 1'b1;
    wait_acks(3, 400);
    if (ack_log.size() >= 3) begin
      check("fair_second_grant", 32'(ack_log[1]), 32'd2);
      check("fair_third_grant", 32'(ack_log[2]), 32'd0);
    end
    hold = '0;
    req_valid = '0;
    wait_idle(200);
    sb_en = 1;
`else
    // Burst: req1 and req3 always valid -> 1,1,1,3,3,3,1.
    begin
      int exp_b[7];
      exp_b = '{1, 1, 1, 3, 3, 3, 1};
      do_reset();
      sb_en = 0;
      hold = 4'b1010;
      req_data = 32'h3300_1100;
      req_valid = 4'b1010;
      wait_acks(7, 1000);
      for (int k = 0; k < 7; k++)
        if (k < ack_log.size()) check("burst_order", 32'(ack_log[k]), 32'(exp_b[k]));
      hold = '0;
      req_valid = '0;
      wait_idle(200);
      sb_en = 1;
    end
`endif

    // Timeout: uart_tx never drops ready -> err at tx_start+7, sticky.
    stuck = 1;
    do_reset();
    seen_start = 0;
    req_data  = 32'h0000_6B5A;
    req_valid = 4'b0001;
    push_exp(0, 8'h5A);
    for (int c = 0; c < 20 && !seen_start; c++) tick();
    check("to_start_seen", 32'(seen_start), 32'h1);
    repeat (6) tick();
    check("to_err_before", 32'(err_timeout), 32'h0);
    check("to_busy_before", 32'(busy), 32'h1);
    tick();
    check("to_err_at_7", 32'(err_timeout), 32'h1);
    check("to_busy_dropped", 32'(busy), 32'h0);
    req_valid = 4'b0010;
    push_exp(1, 8'h6B);
    wait_idle(200);
    repeat (10) tick();
    check("to_err_sticky", 32'(err_timeout), 32'h1);
    stuck = 0;
    do_reset();
    check("to_err_cleared", 32'(err_timeout), 32'h0);

    // Reset in WAIT_DONE: outputs clear without a clock edge, next grant is req 0.
    seen_start = 0;
    req_data  = 32'h0082_8180;
    req_valid = 4'b0110;
    push_exp(1, 8'h81);
    for (int c = 0; c < 20 && !seen_start; c++) tick();
    check("mf_start_seen", 32'(seen_start), 32'h1);
    tick();
    tick();
    check("mf_in_frame", 32'({busy, tx_ready}), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("mf_tx_data", 32'(tx_data), 32'h0);
    check("mf_grant_id", 32'(grant_id), 32'h0);
    check("mf_busy", 32'(busy), 32'h0);
    check("mf_req_ack", 32'({req_ack, tx_start}), 32'h0);
    tx_q.delete();
    ack_q.delete();
    frame_cnt = 0;
    tx_ready  = 1'b1;
    req_valid = 4'b0101;
    push_exp(0, 8'h80);
    push_exp(2, 8'h82);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
